// File: rtl/fdpe_bank_sequencer_pkg.sv
// Shared types and legal parameter ranges for the FDPE bank reset/clock-enable sequencer.
package fdpe_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_RELEASE,
        ST_RUN
    } seq_state_e;

    localparam int NUM_BANKS_MIN = 1;
    localparam int NUM_BANKS_MAX = 16;
    localparam int HOLD_CYC_MIN  = 1;
    localparam int STAGE_DLY_MIN = 1;

    function automatic int max2(int a, int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fdpe_bank_sequencer_if.sv
// Control/status bundle between the sequencer and its controller/flop banks.
interface fdpe_bank_sequencer_if #(
    parameter int NUM_BANKS = 4,
    parameter int DIV_W     = 8
);
    logic                 REQ;
    logic [DIV_W-1:0]     DIV;
    logic [NUM_BANKS-1:0] CE_EN;
    logic [NUM_BANKS-1:0] PRE;
    logic [NUM_BANKS-1:0] CE;
    logic                 BUSY;
    logic                 DONE;

    modport master (output REQ, DIV, CE_EN, input PRE, CE, BUSY, DONE);
    modport slave  (input REQ, DIV, CE_EN, output PRE, CE, BUSY, DONE);
endinterface

// File: rtl/fdpe_bank_sequencer_ce_strobe_gen.sv
// Programmable-rate clock-enable strobe; held cleared until the cycle RUN begins.
module ce_strobe_gen #(
    parameter int NUM_BANKS = 4,
    parameter int DIV_W     = 8
) (
    input  logic                 C,
    input  logic                 clear,
    input  logic                 run,
    input  logic [DIV_W-1:0]     div,
    input  logic [NUM_BANKS-1:0] ce_en,
    output logic [NUM_BANKS-1:0] ce
);
    logic [DIV_W-1:0] cnt;

    // ce is the registered strobe already gated by the mask, so a mask change shows one cycle later.
    always_ff @(posedge C) begin
        if (clear || !run) begin
            cnt <= '0;
            ce  <= '0;
        end else begin
            ce  <= (cnt == '0) ? ce_en : '0;
            cnt <= (cnt == div) ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/fdpe_bank_sequencer.sv
// Holds all flop-bank presets, releases them one bank at a time, then runs a shared CE strobe.
module fdpe_bank_sequencer
    import fdpe_seq_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int HOLD_CYC  = 16,
    parameter int STAGE_DLY = 8,
    parameter int DIV_W     = 8
) (
    input  logic                  C,
    input  logic                  R,
    fdpe_bank_sequencer_if.slave  bus
);
    localparam int CNT_W = $clog2(max2(HOLD_CYC, STAGE_DLY) + 1);
    localparam int IDX_W = $clog2(NUM_BANKS + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);
    localparam logic [IDX_W-1:0] LAST_BANK  = IDX_W'(NUM_BANKS - 1);

    if (NUM_BANKS < NUM_BANKS_MIN || NUM_BANKS > NUM_BANKS_MAX ||
        HOLD_CYC < HOLD_CYC_MIN || STAGE_DLY < STAGE_DLY_MIN) begin : g_bad_params
        $error("fdpe_bank_sequencer: parameter out of range");
    end

    seq_state_e           state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [IDX_W-1:0]     idx, idx_nxt;
    logic [NUM_BANKS-1:0] pre, pre_nxt;
    logic [DIV_W-1:0]     div_q;
    logic                 done;
    logic                 restart;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        pre_nxt   = pre;
        restart   = R || (state == ST_RUN && bus.REQ);
        if (restart) begin
            state_nxt = ST_ASSERT;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            pre_nxt   = '1;
        end else begin
            case (state)
                ST_ASSERT: begin
                    if (cnt == HOLD_LAST) begin
                        state_nxt  = ST_RELEASE;
                        cnt_nxt    = '0;
                        pre_nxt[0] = 1'b0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt == STAGE_LAST) begin
                        cnt_nxt = '0;
                        // The last bank still gets a full stage before RUN.
                        if (idx == LAST_BANK) begin
                            state_nxt = ST_RUN;
                        end else begin
                            idx_nxt = idx + 1'b1;
                            pre_nxt = pre & ~(NUM_BANKS'(1) << (idx + 1'b1));
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_RUN:  ;
                default: state_nxt = ST_ASSERT;
            endcase
        end
    end

    always_ff @(posedge C) begin
        if (R) begin
            state <= ST_ASSERT;
            cnt   <= '0;
            idx   <= '0;
            pre   <= '1;
            done  <= 1'b0;
            div_q <= bus.DIV;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            pre   <= pre_nxt;
            done  <= (state != ST_RUN) && (state_nxt == ST_RUN);
            if (restart) div_q <= bus.DIV;
        end
    end

    ce_strobe_gen #(.NUM_BANKS(NUM_BANKS), .DIV_W(DIV_W)) u_strobe (
        .C     (C),
        .clear (R),
        .run   (state_nxt == ST_RUN),
        .div   (div_q),
        .ce_en (bus.CE_EN),
        .ce    (bus.CE)
    );

    assign bus.PRE  = pre;
    assign bus.BUSY = (state != ST_RUN);
    assign bus.DONE = done;
endmodule
